std_seq_mem_d1: RTL and testbench

Parametrised single-port 1-D memory with a registered, pipelined read path. Successor to the combinational-read 1-D memory primitive: reads are sequential, with configurable latency and a per-request done pulse. It is fully pipelined and accepts one request per cycle. Used by the compiler wherever a memory must map to synchronous block RAM.

---
 rtl/std_seq_mem_d1_if.sv | 32 +++
 rtl/std_seq_mem_d1.sv | 115 +++++++++++
 tb/tb_std_seq_mem_d1.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/std_seq_mem_d1_if.sv
// Request/response bundle for std_seq_mem_d1.
// The master side (compiler-generated logic or a testbench) drives requests.
// The slave side (the memory) returns done and read_data.
interface std_seq_mem_d1_if #(
    parameter int WIDTH    = 32,
    parameter int IDX_SIZE = 4
);
    logic [IDX_SIZE-1:0] addr0;
    logic [WIDTH-1:0]    write_data;
    logic                write_en;
    logic                read_en;
    logic [WIDTH-1:0]    read_data;
    logic                done;

    modport master (
        output addr0,
        output write_data,
        output write_en,
        output read_en,
        input  read_data,
        input  done
    );

    modport slave (
        input  addr0,
        input  write_data,
        input  write_en,
        input  read_en,
        output read_data,
        output done
    );
endinterface

// File: rtl/std_seq_mem_d1.sv
// std_seq_mem_d1: single-port 1-D memory with a pipelined, registered read path.
//
// The module accepts one request per cycle and applies no backpressure.
// A request accepted in cycle T raises done in cycle T+LATENCY.
// For a read, the same cycle T+LATENCY also presents the read data on read_data.
// When a read and a write hit the same cycle, the read returns write_data (write-first).
// read_data holds its value across write-only completions and idle cycles.
// Reset is synchronous and active-high. It flushes the pipeline but leaves the memory array untouched.
//
// Optional feature: define STD_SEQ_MEM_OOB_GUARD_EN to add an out-of-bounds guard.
// With the guard, a request with addr0 >= SIZE writes nothing and reads back 0.
// done still pulses for that request, and simulation reports it with $error.
// Without the macro there is no bounds logic, and addresses >= SIZE are undefined.
//
// LATENCY must lie in 1..8; IDX_SIZE must be wide enough to address SIZE words.
module std_seq_mem_d1 #(
    parameter int WIDTH    = 32,
    parameter int SIZE     = 16,
    parameter int IDX_SIZE = 4,
    parameter int LATENCY  = 1
) (
    input  logic              clk,
    input  logic              reset,
    std_seq_mem_d1_if.slave   bus
);

    logic [WIDTH-1:0] mem [SIZE];

    logic             stage_valid   [LATENCY];
    logic             stage_is_read [LATENCY];
    logic [WIDTH-1:0] stage_data    [LATENCY];

    logic             nxt_valid     [LATENCY];
    logic             nxt_is_read   [LATENCY];
    logic [WIDTH-1:0] nxt_data      [LATENCY];

    logic             req_accept;
    logic             wr_commit;
    logic [WIDTH-1:0] rd_sample;
    logic [WIDTH-1:0] read_data_q;

    assign req_accept = !reset && (bus.read_en || bus.write_en);

`ifdef STD_SEQ_MEM_OOB_GUARD_EN
    logic oob;

    // An address at or beyond SIZE is out of bounds; one extra bit lets SIZE == 2**IDX_SIZE compare correctly
    assign oob = ({1'b0, bus.addr0} >= (IDX_SIZE + 1)'(SIZE));

    // Write-first sample of the addressed word; out-of-bounds words read as zero and are never written
    always_comb begin
        rd_sample = '0;
        wr_commit = 1'b0;
        if (!oob) begin
            rd_sample = bus.write_en ? bus.write_data : mem[bus.addr0];
            wr_commit = !reset && bus.write_en;
        end
    end

    // Report each accepted out-of-bounds request so simulation flags the offending compiler output
    always_ff @(posedge clk) begin
        if (req_accept && oob) begin
            $error("std_seq_mem_d1: out-of-bounds access addr0=%0d SIZE=%0d", bus.addr0, SIZE);
        end
    end
`else
    // Write-first sample of the addressed word; the address is trusted to be in range
    always_comb begin
        rd_sample = bus.write_en ? bus.write_data : mem[bus.addr0];
        wr_commit = !reset && bus.write_en;
    end
`endif

    // Storage array with no reset, so synthesis can map it onto block RAM
    always_ff @(posedge clk) begin
        if (wr_commit) begin
            mem[bus.addr0] <= bus.write_data;
        end
    end

    // Next-state view of the pipeline: stage 0 takes the new request, every later stage takes its predecessor
    always_comb begin
        nxt_valid[0]   = req_accept;
        nxt_is_read[0] = bus.read_en;
        nxt_data[0]    = rd_sample;
        for (int k = 1; k < LATENCY; k++) begin
            nxt_valid[k]   = stage_valid[k-1];
            nxt_is_read[k] = stage_is_read[k-1];
            nxt_data[k]    = stage_data[k-1];
        end
    end

    // Advance the pipeline; read_data loads at the same edge the final stage does, so it appears with done
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < LATENCY; k++) begin
                stage_valid[k] <= 1'b0;
            end
            read_data_q <= '0;
        end else begin
            for (int k = 0; k < LATENCY; k++) begin
                stage_valid[k]   <= nxt_valid[k];
                stage_is_read[k] <= nxt_is_read[k];
                stage_data[k]    <= nxt_data[k];
            end
            if (nxt_valid[LATENCY-1] && nxt_is_read[LATENCY-1]) begin
                read_data_q <= nxt_data[LATENCY-1];
            end
        end
    end

    assign bus.done      = stage_valid[LATENCY-1];
    assign bus.read_data = read_data_q;

endmodule

// File: tb/tb_std_seq_mem_d1.sv
// Testbench for std_seq_mem_d1.
// Two instances run side by side on the same request stream: one with LATENCY=1 and one with LATENCY=3.
// Each instance has its own scoreboard queue that acts as a delay line of expected completions.
// Every driven cycle pushes an entry for that cycle's request.
// Every observed cycle pops the matching entry and compares done and read_data against it.
module tb_std_seq_mem_d1;

    localparam int WIDTH = 32;
    localparam int SIZE  = 16;
    localparam int IDX   = 4;
    localparam int LAT_A = 1;
    localparam int LAT_B = 3;

    typedef struct packed {
        logic             valid;
        logic             is_read;
        logic [WIDTH-1:0] data;
    } exp_t;

    logic clk;
    logic reset;

    std_seq_mem_d1_if #(.WIDTH(WIDTH), .IDX_SIZE(IDX)) bus_a ();
    std_seq_mem_d1_if #(.WIDTH(WIDTH), .IDX_SIZE(IDX)) bus_b ();

    std_seq_mem_d1 #(.WIDTH(WIDTH), .SIZE(SIZE), .IDX_SIZE(IDX), .LATENCY(LAT_A)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a.slave)
    );

    std_seq_mem_d1 #(.WIDTH(WIDTH), .SIZE(SIZE), .IDX_SIZE(IDX), .LATENCY(LAT_B)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b.slave)
    );

    // The second instance sees exactly the requests driven onto the first
    assign bus_b.addr0      = bus_a.addr0;
    assign bus_b.write_data = bus_a.write_data;
    assign bus_b.write_en   = bus_a.write_en;
    assign bus_b.read_en    = bus_a.read_en;

    exp_t             sb_a [$];
    exp_t             sb_b [$];
    logic [WIDTH-1:0] exp_rd_a;
    logic [WIDTH-1:0] exp_rd_b;
    logic [WIDTH-1:0] model_mem [SIZE];
    int               tests;
    int               failures;
    int               cycle;

    // Free-running clock, posedge active
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
        tests++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s cycle %0d: got 0x%08h expected 0x%08h", tag, cycle, got, exp);
        end
    endtask

    task automatic flushScoreboards();
        sb_a.delete();
        sb_b.delete();
        for (int i = 0; i < LAT_A - 1; i++) sb_a.push_back('0);
        for (int i = 0; i < LAT_B - 1; i++) sb_b.push_back('0);
        exp_rd_a = '0;
        exp_rd_b = '0;
    endtask

    task automatic applyStimulus(input logic rst, input logic re, input logic we,
                                 input logic [IDX-1:0] addr, input logic [WIDTH-1:0] wd);
        exp_t e;
        exp_t ea;
        exp_t eb;
        @(negedge clk);
        reset             = rst;
        bus_a.read_en     = re;
        bus_a.write_en    = we;
        bus_a.addr0       = addr;
        bus_a.write_data  = wd;
        e.valid   = !rst && (re || we);
        e.is_read = re;
        e.data    = we ? wd : model_mem[addr];
        if (!rst && we) model_mem[addr] = wd;
        sb_a.push_back(e);
        sb_b.push_back(e);
        @(posedge clk);
        #1;
        cycle++;
        if (rst) begin
            flushScoreboards();
            checkOutput("A reset done", {31'b0, bus_a.done}, '0);
            checkOutput("A reset read_data", bus_a.read_data, '0);
            checkOutput("B reset done", {31'b0, bus_b.done}, '0);
            checkOutput("B reset read_data", bus_b.read_data, '0);
        end else begin
            ea = sb_a.pop_front();
            eb = sb_b.pop_front();
            if (ea.valid && ea.is_read) exp_rd_a = ea.data;
            if (eb.valid && eb.is_read) exp_rd_b = eb.data;
            checkOutput("A done", {31'b0, bus_a.done}, {31'b0, ea.valid});
            checkOutput("A read_data", bus_a.read_data, exp_rd_a);
            checkOutput("B done", {31'b0, bus_b.done}, {31'b0, eb.valid});
            checkOutput("B read_data", bus_b.read_data, exp_rd_b);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    // Directed scenarios first, then a randomized stream with occasional resets
    initial begin
        tests    = 0;
        failures = 0;
        cycle    = 0;
        reset             = 1'b1;
        bus_a.read_en     = 1'b0;
        bus_a.write_en    = 1'b0;
        bus_a.addr0       = '0;
        bus_a.write_data  = '0;
        for (int i = 0; i < SIZE; i++) model_mem[i] = '0;
        flushScoreboards();

        applyStimulus(1'b1, 1'b0, 1'b0, '0, '0);
        applyStimulus(1'b1, 1'b0, 1'b0, '0, '0);

        // Preload every word back to back, so done stays high continuously
        for (int i = 0; i < SIZE; i++) applyStimulus(1'b0, 1'b0, 1'b1, IDX'(i), 32'hA000_0000 + 32'(i * 17));
        idle(LAT_B);

        // Write then immediate read of the same address
        applyStimulus(1'b0, 1'b0, 1'b1, 4'd3, 32'hDEADBEEF);
        applyStimulus(1'b0, 1'b1, 1'b0, 4'd3, '0);
        idle(LAT_B);

        // Back-to-back reads of freshly written words
        applyStimulus(1'b0, 1'b0, 1'b1, 4'd0, 32'd10);
        applyStimulus(1'b0, 1'b0, 1'b1, 4'd1, 32'd20);
        applyStimulus(1'b0, 1'b0, 1'b1, 4'd2, 32'd30);
        applyStimulus(1'b0, 1'b1, 1'b0, 4'd0, '0);
        applyStimulus(1'b0, 1'b1, 1'b0, 4'd1, '0);
        applyStimulus(1'b0, 1'b1, 1'b0, 4'd2, '0);
        idle(LAT_B + 1);

        // Read and write together in one cycle: write-first, then a later read confirms the commit
        applyStimulus(1'b0, 1'b0, 1'b1, 4'd5, 32'h11);
        applyStimulus(1'b0, 1'b1, 1'b1, 4'd5, 32'h55);
        idle(LAT_B);
        applyStimulus(1'b0, 1'b1, 1'b0, 4'd5, '0);
        idle(LAT_B);

        // A write-only completion leaves read_data holding the last read value
        applyStimulus(1'b0, 1'b0, 1'b1, 4'd1, 32'h77);
        applyStimulus(1'b0, 1'b1, 1'b0, 4'd1, '0);
        idle(LAT_B);
        applyStimulus(1'b0, 1'b0, 1'b1, 4'd1, 32'h99);
        idle(LAT_B);
        applyStimulus(1'b0, 1'b1, 1'b0, 4'd1, '0);
        idle(LAT_B);

        // A reset mid-flight drops the pending read; a write presented during reset is ignored
        applyStimulus(1'b0, 1'b1, 1'b0, 4'd3, '0);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
        applyStimulus(1'b1, 1'b0, 1'b1, 4'd4, 32'h0BAD_0BAD);
        idle(LAT_B + 1);
        applyStimulus(1'b0, 1'b1, 1'b0, 4'd3, '0);
        applyStimulus(1'b0, 1'b1, 1'b0, 4'd4, '0);
        idle(LAT_B);

        // Random traffic with occasional resets
        for (int i = 0; i < 300; i++) begin
            logic rst;
            logic re;
            logic we;
            rst = ($urandom_range(0, 39) == 0);
            re  = $urandom_range(0, 1) == 1;
            we  = $urandom_range(0, 2) == 0;
            applyStimulus(rst, re, we, IDX'($urandom_range(0, SIZE - 1)), $urandom);
        end
        idle(LAT_B + 1);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
